// File: rtl/sma4_window_pkg.sv
// rtl/sma4_window_pkg.sv - shared constants, state enum and helpers for the 4-sample moving average
package sma4_window_pkg;

  localparam int WIN_DEPTH = 4;
  localparam int PTR_W     = 2;
  localparam int CNT_W     = 3;

  typedef enum logic {
    ST_FILLING = 1'b0,
    ST_FULL    = 1'b1
  } sma_state_e;

  // Window occupancy grows by one per accepted sample and saturates at the depth
  function automatic logic [CNT_W-1:0] fill_next(input logic [CNT_W-1:0] cnt);
    if (cnt == CNT_W'(WIN_DEPTH)) begin
      return cnt;
    end
    return cnt + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sma4_window_mux4.sv
// rtl/sma4_window_mux4.sv - width-generic 4:1 multiplexer
module sma4_window_mux4 #(
  parameter int W = 16
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [1:0]   sel,
  output logic [W-1:0] y
);

  always_comb begin
    y = d0;
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/sma4_window.sv
// rtl/sma4_window.sv - 4-sample moving sum/average over a circular window with valid/ready handshake
module sma4_window
  import sma4_window_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_price,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_avg,
  output logic [DATA_W+1:0] out_sum,
  output logic [2:0]        fill_cnt
);

  localparam int SUM_W = DATA_W + 2;

  logic [DATA_W-1:0] win_q [WIN_DEPTH];
  logic [DATA_W-1:0] win_d [WIN_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]  fill_q, fill_d;
  sma_state_e        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [SUM_W-1:0]  out_sum_q, out_sum_d;
  logic [DATA_W-1:0] out_avg_q, out_avg_d;

  logic [DATA_W-1:0] oldest;
  logic              accept;
  logic              qualify;

  // The slot about to be overwritten is the oldest sample once the window is full
  sma4_window_mux4 #(.W(DATA_W)) u_oldest_mux (
    .d0  (win_q[0]),
    .d1  (win_q[1]),
    .d2  (win_q[2]),
    .d3  (win_q[3]),
    .sel (wr_ptr_q),
    .y   (oldest)
  );

  assign in_ready = rst_n && !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign qualify  = accept && (fill_q >= CNT_W'(WIN_DEPTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILLING: if (accept && fill_q == CNT_W'(WIN_DEPTH - 1)) state_d = ST_FULL;
      ST_FULL:    state_d = ST_FULL;
      default:    state_d = ST_FILLING;
    endcase
    if (flush) begin
      state_d = ST_FILLING;
    end
  end

  always_comb begin
    win_d       = win_q;
    wr_ptr_d    = wr_ptr_q;
    sum_d       = sum_q;
    fill_d      = fill_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_avg_d   = out_avg_q;

    if (flush) begin
      wr_ptr_d    = '0;
      sum_d       = '0;
      fill_d      = '0;
      out_valid_d = 1'b0;
      out_sum_d   = '0;
      out_avg_d   = '0;
    end else begin
      if (accept) begin
        win_d[wr_ptr_q] = in_price;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        sum_d           = sum_q + SUM_W'(in_price)
                          - ((state_q == ST_FULL) ? SUM_W'(oldest) : '0);
        fill_d          = fill_next(fill_q);
      end
      // A new result may replace one being consumed in the same cycle
      if (qualify) begin
        out_valid_d = 1'b1;
        out_sum_d   = sum_d;
        out_avg_d   = sum_d[SUM_W-1:2];
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Entries are always written before they are read, so the window needs no reset
  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      sum_q       <= '0;
      fill_q      <= '0;
      state_q     <= ST_FILLING;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_avg_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      sum_q       <= sum_d;
      fill_q      <= fill_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_avg_q   <= out_avg_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_avg   = out_avg_q;
  assign fill_cnt  = fill_q;

endmodule

// File: tb/tb_sma4_window.sv
// tb/tb_sma4_window.sv - scoreboard bench for sma4_window with a queue-based window model
module tb_sma4_window;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_price = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_avg;
  logic [17:0] out_sum;
  logic [2:0]  fill_cnt;

  int checks = 0;
  int errors = 0;

  logic [17:0] exp_q[$];
  logic [15:0] win[$];
  bit          mdl_ov = 1'b0;

  sma4_window #(.DATA_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_price  (in_price),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_avg   (out_avg),
    .out_sum   (out_sum),
    .fill_cnt  (fill_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit mdl_in_ready();
    return rst_n && !flush && (!mdl_ov || out_ready);
  endfunction

  // Asynchronous reset discards the window and any pending result
  always @(negedge rst_n) begin
    exp_q.delete();
    win.delete();
    mdl_ov = 1'b0;
  end

  // Reference model: evaluates the upcoming edge after the monitor has sampled
  always begin
    bit qual;
    int s;
    @(negedge clk);
    #2;
    if (rst_n && flush) begin
      win.delete();
      exp_q.delete();
      mdl_ov = 1'b0;
    end else if (rst_n) begin
      qual = 1'b0;
      if (in_valid && mdl_in_ready()) begin
        win.push_back(in_price);
        if (win.size() > 4) void'(win.pop_front());
        if (win.size() == 4) begin
          s = 0;
          foreach (win[i]) s += int'(win[i]);
          exp_q.push_back(18'(s));
          qual = 1'b1;
        end
      end
      if (qual) mdl_ov = 1'b1;
      else if (out_ready) mdl_ov = 1'b0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    logic [17:0] es;
    chk("in_ready", 64'(in_ready), 64'(mdl_in_ready()));
    chk("out_valid", 64'(out_valid), 64'(mdl_ov));
    chk("fill_cnt", 64'(fill_cnt), 64'(win.size()));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got sum %0h expected none", out_sum);
      end else begin
        es = exp_q.pop_front();
        chk("sb_sum", 64'(out_sum), 64'(es));
        chk("sb_avg", 64'(out_avg), 64'(es / 4));
      end
    end
  end

  task automatic send(input logic [15:0] p);
    int n;
    in_valid = 1'b1;
    in_price = p;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_out(input string nm, input logic [17:0] s, input logic [15:0] a);
    chk({nm, "_valid"}, 64'(out_valid), 64'd1);
    chk({nm, "_sum"}, 64'(out_sum), 64'(s));
    chk({nm, "_avg"}, 64'(out_avg), 64'(a));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fill", 64'(fill_cnt), 64'd0);
    chk("rst_sum", 64'(out_sum), 64'd0);
    chk("rst_avg", 64'(out_avg), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(16'd10);
    send(16'd20);
    send(16'd30);
    chk("fill3_no_out", 64'(out_valid), 64'd0);
    chk("fill3_cnt", 64'(fill_cnt), 64'd3);
    send(16'd40);
    chk_out("first", 18'd100, 16'd25);
    chk("full_cnt", 64'(fill_cnt), 64'd4);
    send(16'd50);
    chk_out("s50", 18'd140, 16'd35);
    send(16'd60);
    chk_out("s60", 18'd180, 16'd45);

    repeat (4) send(16'hFFFF);
    chk_out("fullscale", 18'h3FFFC, 16'hFFFF);

    out_ready = 1'b0;
    in_valid = 1'b1;
    in_price = 16'h1000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk_out("stall", 18'h3FFFC, 16'hFFFF);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk_out("release", 18'h30FFD, 16'hC3FF);

    flush = 1'b1;
    in_valid = 1'b1;
    in_price = 16'h7777;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_fill", 64'(fill_cnt), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    send(16'd1);
    send(16'd2);
    send(16'd3);
    send(16'd4);
    chk_out("post_flush", 18'd10, 16'd2);

    send(16'd5);
    send(16'd6);
    rst_n = 1'b0;
    #1;
    chk("midrst_fill", 64'(fill_cnt), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(16'd7);
    send(16'd8);
    send(16'd9);
    send(16'd10);
    chk_out("post_rst", 18'd34, 16'd8);

    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_price  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sma4_window.md
SMA4_WINDOW -- requirements
Module: sma4_window

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the price sample width in bits (unsigned).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port flush, input, 1 bit: synchronous clear of the window and output register.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_price is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-007 The block SHALL have port in_price, input, DATA_W bits: new price sample.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_avg and out_sum are valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the output this cycle.
REQ-010 The block SHALL have port out_avg, output, DATA_W bits: 4-sample moving average.
REQ-011 The block SHALL have port out_sum, output, DATA_W+2 bits: 4-sample window sum.
REQ-012 The block SHALL have port fill_cnt, output, 3 bits: number of samples held in the window (0..4).

Function
REQ-013 The window SHALL be a 4-entry circular buffer with a 2-bit write pointer wr_ptr; the oldest entry SHALL be read by 4:1 selection of the buffer using wr_ptr as the select.
REQ-014 A sample SHALL be accepted when in_valid && in_ready; in_ready SHALL be (!out_valid || out_ready) && !flush.
REQ-015 On accept: buf[wr_ptr] <= in_price; wr_ptr <= wr_ptr+1 (wraps 3->0); sum <= sum + in_price - (fill_cnt==4 ? buf[wr_ptr] : 0).
REQ-016 fill_cnt SHALL increment on each accept until it reaches 4, then saturate at 4.
REQ-017 The control state SHALL be FILLING while fill_cnt<4 and FULL when fill_cnt==4; FILLING->FULL on the 4th accept; FULL->FILLING only on flush or reset.
REQ-018 An output SHALL be produced only for accepts that leave fill_cnt==4 (the 4th accept and every later one); accepts in FILLING that leave fill_cnt<4 produce no output.
REQ-019 Latency SHALL be 1 cycle: out_valid rises the cycle after the qualifying accept, with out_sum equal to the updated sum and out_avg = out_sum >> 2 (truncation, no rounding).
REQ-020 out_sum SHALL be DATA_W+2 bits so that 4 samples of full-scale value never overflow; the internal sum SHALL use the same width.
REQ-021 While out_valid && !out_ready, out_valid, out_avg and out_sum SHALL hold stable and no sample is accepted.
REQ-022 When out_valid && out_ready && a qualifying accept occur in the same cycle, the output register SHALL reload with the new result and out_valid SHALL remain 1 (full throughput, one result per cycle).
REQ-023 When out_valid && out_ready occur without a qualifying accept, out_valid SHALL drop to 0 on the next cycle.
REQ-024 When flush is 1, on the next edge wr_ptr, sum, fill_cnt and out_valid SHALL become 0, and any concurrent in_valid SHALL be ignored (in_ready is 0).

Reset
REQ-025 On rst_n low, asynchronously: wr_ptr=0, sum=0, fill_cnt=0, out_valid=0, out_avg=0, out_sum=0, state=FILLING; buffer contents SHALL need no reset, because an entry is never read before it is written.
REQ-026 While rst_n is low, in_ready SHALL be 0; reset asserted mid-stream SHALL discard all window contents and any pending output.

Structure
REQ-027 The FILLING/FULL state enum and the window depth constant (4) SHALL be placed in a shared SMA package.
REQ-028 The oldest-entry selection SHALL instantiate the existing 4:1 mux sub-module, replicated per bit or width-generalised; all other logic SHALL stay in this module.

Verification
REQ-029 The bench SHALL drive 10,20,30,40 back-to-back with out_ready=1 and SHALL check that there is no output for the first 3 samples, then out_sum=100 and out_avg=25 one cycle after the 4th sample.
REQ-030 The bench SHALL continue with 50 and check out_sum=140 and out_avg=35; it SHALL then check that 60 gives out_sum=180, out_avg=45 (wr_ptr wrap and oldest-entry subtraction).
REQ-031 The bench SHALL drive 4 samples of 0xFFFF (DATA_W=16) and check out_sum=0x3FFFC and out_avg=0xFFFF, with no overflow.
REQ-032 The bench SHALL hold out_ready=0 with a valid output and in_valid=1, and check that in_ready=0 and the outputs are stable for 5 cycles; on release, it SHALL check that the held result is taken and the next sample is accepted in the same cycle.
REQ-033 The bench SHALL assert flush with in_valid=1 in the FULL state, and check that the sample is dropped and that fill_cnt=0 and out_valid=0 on the next cycle; it SHALL then drive 1,2,3,4 and check out_sum=10, out_avg=2.
REQ-034 The bench SHALL assert rst_n low for one cycle after 2 accepts, and check that fill_cnt=0 immediately; it SHALL then drive 4 samples and check that the first output covers only the post-reset samples.
